// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// instr_fetch : single-outstanding instruction fetch unit feeding a 2-entry
//               {instr, pc} buffer, with redirect flush and stale-data drop.
// Revision    : 1.0
// ============================================================================

module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  count_q, count_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [31:0] buf_instr_q [2];
  logic [31:0] buf_pc_q    [2];

  logic        push;
  logic        pop;
  logic [1:0]  count_after_push;
  logic [31:0] redirect_pc_aligned;

  assign imem_req            = (state_q == S_REQ);
  assign imem_addr           = fetch_pc_q;
  assign instr_valid         = (count_q != 2'd0);
  assign instr               = buf_instr_q[rd_ptr_q];
  assign instr_pc            = buf_pc_q[rd_ptr_q];
  assign pop                 = instr_valid & instr_ready;
  assign count_after_push    = count_q + 2'd1 - {1'b0, pop};
  assign redirect_pc_aligned = redirect_pc & 32'hFFFF_FFFC;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (redirect || (count_q < 2'd2)) state_d = S_REQ;
      end
      S_REQ: begin
        if (imem_ready) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = redirect ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (redirect) begin
            state_d = S_REQ;
          end else begin
            push    = 1'b1;
            state_d = (count_after_push < 2'd2) ? S_REQ : S_IDLE;
          end
        end else if (redirect) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        // The returning response belongs to a flushed request; only its arrival matters.
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect) fetch_pc_d = redirect_pc_aligned;
  end

  always_comb begin
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    if (redirect) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // A push only happens in WAIT, where fetch_pc already points one word past the data.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr_q[wr_ptr_q] <= imem_rdata;
      buf_pc_q[wr_ptr_q]    <= fetch_pc_q - 32'd4;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// tb_instr_fetch : directed self-checking bench for instr_fetch.
// Revision       : 1.0
// ============================================================================

module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        rst2_n;
  logic        req2;
  logic [31:0] addr2;
  logic        ready2;
  logic        rvalid2;
  logic [31:0] rdata2;
  logic [31:0] instr2;
  logic [31:0] pc2;
  logic        valid2;
  logic        instr_ready2;
  logic        redirect2;
  logic [31:0] redirect_pc2;

  int checks   = 0;
  int failures = 0;

  bit          auto_en;
  int          lat;
  bit          pend;
  int          pend_cnt;
  logic [31:0] pend_addr;
  logic [31:0] acc_q[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_ins[$];

  instr_fetch u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (
    .clk        (clk),
    .rst_n      (rst2_n),
    .imem_req   (req2),
    .imem_addr  (addr2),
    .imem_ready (ready2),
    .imem_rvalid(rvalid2),
    .imem_rdata (rdata2),
    .instr      (instr2),
    .instr_pc   (pc2),
    .instr_valid(valid2),
    .instr_ready(instr_ready2),
    .redirect   (redirect2),
    .redirect_pc(redirect_pc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dfun(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory model: accepts when idle, returns data lat cycles after acceptance.
  task automatic mem_step();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = dfun(pend_addr);
        pend        = 1'b0;
      end
    end
    imem_ready = 1'b0;
    if (auto_en && imem_req && !pend) begin
      imem_ready = 1'b1;
      pend       = 1'b1;
      pend_cnt   = lat;
      pend_addr  = imem_addr;
      acc_q.push_back(imem_addr);
    end
  endtask

  task automatic tick();
    if (instr_valid && instr_ready) begin
      got_pc.push_back(instr_pc);
      got_ins.push_back(instr);
    end
    @(negedge clk);
    mem_step();
  endtask

  task automatic wait_consumed(input int n, input int budget, input string tag);
    int k = 0;
    while (got_pc.size() < n && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (got_pc.size() < n) begin
      failures++;
      $display("FAIL %s_timeout: consumed=%0d required=%0d", tag, got_pc.size(), n);
    end
  endtask

  task automatic wait_req_addr(input logic [31:0] a, input int budget, input string tag);
    int k = 0;
    do begin
      tick();
      k++;
    end while (!(imem_req && imem_addr == a) && k < budget);
    checks++;
    if (!(imem_req && imem_addr == a)) begin
      failures++;
      $display("FAIL %s_timeout: req=%0b addr=%h required addr=%h", tag, imem_req, imem_addr, a);
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    auto_en     = 1'b0;
    pend        = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got_pc.delete();
    got_ins.delete();
    acc_q.delete();
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req: got=%0b exp=0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr: got=%h exp=00000000", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got=%0b exp=0", instr_valid); end
    do_reset();
    tick();
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL first_req: got=%0b exp=1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL first_addr: got=%h exp=00000000", imem_addr); end
    tick();
    checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin
      failures++; $display("FAIL req_hold: req=%0b valid=%0b exp req=1 valid=0", imem_req, instr_valid);
    end
  endtask

  task automatic test_stream();
    do_reset();
    auto_en = 1'b1; lat = 1; instr_ready = 1'b1;
    wait_consumed(6, 100, "stream");
    for (int i = 0; i < 6; i++) begin
      checks++; if (got_pc[i] !== 32'(4 * i)) begin failures++; $display("FAIL stream_pc[%0d]: got=%h exp=%h", i, got_pc[i], 32'(4 * i)); end
      checks++; if (got_ins[i] !== dfun(32'(4 * i))) begin failures++; $display("FAIL stream_ins[%0d]: got=%h exp=%h", i, got_ins[i], dfun(32'(4 * i))); end
      checks++; if (acc_q[i] !== 32'(4 * i)) begin failures++; $display("FAIL stream_addr[%0d]: got=%h exp=%h", i, acc_q[i], 32'(4 * i)); end
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    do_reset();
    auto_en = 1'b1; lat = 1; instr_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i >= 6 && (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== dfun(32'h0))) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_head_stable: unstable_cycles=%0d exp=0", bad); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_req_stalled: got=%0b exp=0", imem_req); end
    checks++; if (acc_q.size() != 2) begin failures++; $display("FAIL bp_accepted: got=%0d exp=2", acc_q.size()); end
    instr_ready = 1'b1;
    tick();
    tick();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL bp_drained: valid=%0b exp=0", instr_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      failures++; $display("FAIL bp_resume: req=%0b addr=%h exp req=1 addr=00000008", imem_req, imem_addr);
    end
    wait_consumed(3, 50, "bp");
    checks++; if (got_pc[0] !== 32'h0 || got_pc[1] !== 32'h4 || got_pc[2] !== 32'h8) begin
      failures++; $display("FAIL bp_order: got=%h,%h,%h exp=0,4,8", got_pc[0], got_pc[1], got_pc[2]);
    end
  endtask

  task automatic test_drop();
    do_reset();
    auto_en = 1'b1; lat = 4; instr_ready = 1'b1;
    wait_req_addr(32'h10, 200, "drop_req10");
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect = 1'b0;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h100) begin
      failures++; $display("FAIL drop_state: req=%0b addr=%h exp req=0 addr=00000100", imem_req, imem_addr);
    end
    tick();
    tick();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL drop_hold: req=%0b exp=0", imem_req); end
    wait_consumed(5, 100, "drop");
    checks++; if (got_pc[3] !== 32'hC) begin failures++; $display("FAIL drop_pre: got=%h exp=0000000c", got_pc[3]); end
    checks++; if (got_pc[4] !== 32'h100 || got_ins[4] !== dfun(32'h100)) begin
      failures++; $display("FAIL drop_next: pc=%h ins=%h exp pc=00000100 ins=%h", got_pc[4], got_ins[4], dfun(32'h100));
    end
    checks++; if (acc_q[5] !== 32'h100) begin failures++; $display("FAIL drop_addr: got=%h exp=00000100", acc_q[5]); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    auto_en = 1'b1; lat = 1; instr_ready = 1'b1;
    wait_req_addr(32'h8, 100, "sim_req8");
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin
      failures++; $display("FAIL sim_rvalid_redirect: req=%0b addr=%h valid=%0b exp 1/00000100/0", imem_req, imem_addr, instr_valid);
    end
    wait_consumed(3, 50, "sim");
    checks++; if (got_pc[2] !== 32'h100 || got_ins[2] !== dfun(32'h100)) begin
      failures++; $display("FAIL sim_next: pc=%h ins=%h exp pc=00000100 ins=%h", got_pc[2], got_ins[2], dfun(32'h100));
    end
    instr_ready = 1'b0;
    repeat (12) tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0200; instr_ready = 1'b1;
    tick();
    redirect = 1'b0; instr_ready = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL pop_redirect_flush: valid=%0b exp=0", instr_valid); end
    got_pc.delete(); got_ins.delete();
    instr_ready = 1'b1;
    wait_consumed(1, 50, "pop_redirect");
    checks++; if (got_pc[0] !== 32'h200 || got_ins[0] !== dfun(32'h200)) begin
      failures++; $display("FAIL pop_redirect_next: pc=%h ins=%h exp pc=00000200", got_pc[0], got_ins[0]);
    end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    got_pc.delete(); got_ins.delete();
    checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL align_addr: got=%h exp=00000100", imem_addr); end
    wait_consumed(1, 50, "align");
    checks++; if (got_pc[0] !== 32'h100) begin failures++; $display("FAIL align_pc: got=%h exp=00000100", got_pc[0]); end

    rst2_n = 1'b0; ready2 = 1'b0; rvalid2 = 1'b0; rdata2 = 32'h0;
    instr_ready2 = 1'b1; redirect2 = 1'b0; redirect_pc2 = 32'h0;
    @(negedge clk);
    checks++; if (req2 !== 1'b0 || addr2 !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap_rst: req=%0b addr=%h exp 0/fffffffc", req2, addr2);
    end
    rst2_n = 1'b1;
    @(negedge clk);
    checks++; if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap_req1: req=%0b addr=%h exp 1/fffffffc", req2, addr2);
    end
    ready2 = 1'b1;
    @(negedge clk);
    ready2 = 1'b0; rvalid2 = 1'b1; rdata2 = 32'h1234_5678;
    checks++; if (req2 !== 1'b0) begin failures++; $display("FAIL wrap_wait: req=%0b exp=0", req2); end
    @(negedge clk);
    rvalid2 = 1'b0;
    checks++; if (req2 !== 1'b1 || addr2 !== 32'h0) begin
      failures++; $display("FAIL wrap_req2: req=%0b addr=%h exp 1/00000000", req2, addr2);
    end
    checks++; if (valid2 !== 1'b1 || pc2 !== 32'hFFFF_FFFC || instr2 !== 32'h1234_5678) begin
      failures++; $display("FAIL wrap_instr: valid=%0b pc=%h ins=%h exp 1/fffffffc/12345678", valid2, pc2, instr2);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    auto_en = 1'b1; lat = 2; instr_ready = 1'b1;
    wait_req_addr(32'h4, 100, "mid_req4");
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      failures++; $display("FAIL mid_rst_out: req=%0b addr=%h valid=%0b exp 0/00000000/0", imem_req, imem_addr, instr_valid);
    end
    tick();
    rst_n = 1'b1;
    got_pc.delete(); got_ins.delete();
    tick();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL mid_stale: valid=%0b exp=0", instr_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++; $display("FAIL mid_first_req: req=%0b addr=%h exp 1/00000000", imem_req, imem_addr);
    end
    wait_consumed(1, 50, "mid");
    checks++; if (got_pc[0] !== 32'h0 || got_ins[0] !== dfun(32'h0)) begin
      failures++; $display("FAIL mid_first_instr: pc=%h ins=%h exp pc=00000000 ins=%h", got_pc[0], got_ins[0], dfun(32'h0));
    end
  endtask

  initial begin
    rst_n = 1'b1; rst2_n = 1'b0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    ready2 = 1'b0; rvalid2 = 1'b0; rdata2 = 32'h0;
    instr_ready2 = 1'b0; redirect2 = 1'b0; redirect_pc2 = 32'h0;
    auto_en = 1'b0; lat = 1; pend = 1'b0; pend_cnt = 0; pend_addr = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_drop();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
